// File: rtl/cla_serial_sum_if.sv
// Nibble-beat handshake bundle for cla_serial_sum: propagate/generate input
// beats on one side, assembled sum/carry/overflow result on the other.
interface cla_serial_sum_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic             cin;
  logic [3:0]       p;
  logic [3:0]       g;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, in_first, in_last, cin, p, g, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, err
  );

  modport slave (
    input  in_valid, in_first, in_last, cin, p, g, out_ready,
    output in_ready, out_valid, sum, cout, ovf, err
  );
endinterface

// File: rtl/cla_serial_sum.sv
// Nibble-serial carry-lookahead sum stage: one p/g nibble per beat, LS nibble
// first, carry held between beats, result presented through a valid/ready output.
module cla_serial_sum #(
  parameter int NIBBLES = 4
) (
  input logic             clk,
  input logic             rst,
  cla_serial_sum_if.slave bus
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int KW    = $clog2(NIBBLES + 1);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic             c_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] sum_q;
  logic             out_valid_q;
  logic             cout_q;
  logic             ovf_q;
  logic             err_q;

  logic             accept;
  logic             nib_ok;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [4:0]       c;
  logic [3:0]       s;
  logic [KW-1:0]    k_sel;
  logic [WIDTH-1:0] psum_d;

  assign p            = bus.p;
  assign g            = bus.g;
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  // A first beat is always legal; otherwise we must be mid-operation with room left.
  assign nib_ok       = bus.in_first || (state_q == ACCUM && k_q != KW'(NIBBLES));

  always_comb begin
    c[0] = bus.in_first ? bus.cin : c_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & c[3]);
    s    = p ^ c[3:0];

    k_sel  = bus.in_first ? '0 : k_q;
    psum_d = bus.in_first ? '0 : psum_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k_sel == KW'(i)) psum_d[4*i +: 4] = s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      c_q         <= 1'b0;
      psum_q      <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        if (nib_ok) begin
          psum_q <= psum_d;
          c_q    <= c[4];
          if (bus.in_last) begin
            state_q     <= IDLE;
            k_q         <= '0;
            sum_q       <= psum_d;
            cout_q      <= c[4];
            ovf_q       <= c[3] ^ c[4];
            out_valid_q <= 1'b1;
          end else begin
            state_q <= ACCUM;
            k_q     <= k_sel + KW'(1);
          end
        end else begin
          err_q <= 1'b1;
          if (state_q == ACCUM) begin
            state_q <= IDLE;
            k_q     <= '0;
          end
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
endmodule

// File: doc/cla_serial_sum.md
# cla_serial_sum

Nibble-serial carry-lookahead sum stage that consumes the per-bit propagate/generate nibbles from the 4-bit half-adder array, one nibble per accepted beat, least-significant nibble first. It computes a 4-bit lookahead carry chain each beat. A registered carry is held between beats. Sum nibbles are assembled into a WIDTH-bit result, presented with carry-out and signed overflow through a valid/ready handshake.

## Interface
- NIBBLES, 4: maximum nibbles per operand; WIDTH = 4*NIBBLES (16 by default).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  nibble beat present.
- in_ready  out  1  stage can accept a beat.
- in_first  in  1  beat is nibble 0 of a new operation.
- in_last  in  1  beat is the final nibble of the operation.
- cin  in  1  carry-in; sampled only on a first beat.
- p  in  4  propagate bits (a^b) of the current nibble.
- g  in  4  generate bits (a&b) of the current nibble.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  assembled sum.
- cout  out  1  carry out of the last accepted nibble.
- ovf  out  1  signed overflow, computed as the carry into bit 3 of the last nibble XOR cout.
- err  out  1  one-cycle pulse flagging a protocol violation.

## Operation
- A beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. The stage can accept the first beat of the next operation in the same cycle the current result is consumed.
- States:
  - IDLE: waits for a first beat.
  - ACCUM: collecting nibbles. The state holds the nibble index k (0..NIBBLES-1), the carry register c, and the partial sum.
  - Results are held in the output register; out_valid is independent of the state.
- Per-beat lookahead, with c0 = cin on a first beat and c0 = c otherwise:
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0
  - c4 = g3 | p3·c3
  - Sum nibble s_i = p_i ^ c_i, written to sum bits [4k+3:4k].
- Accepted first beat (any state):
  - clears the partial sum to zero and sets k = 0;
  - processes the nibble, then stores c = c4 and k = 1;
  - enters ACCUM, or completes immediately if in_last is also set.
- A first beat accepted while in ACCUM aborts the previous operation with no err pulse.
- Accepted non-first beat in ACCUM: processes the nibble at index k, stores c = c4, and increments k.
- Completion on an accepted beat with in_last:
  - the output register loads the sum (nibbles never received read as zero), cout = c4, and ovf = c3 ^ c4;
  - out_valid is set and the state returns to IDLE.
- Protocol violations (err pulses the cycle after acceptance in each case):
  - A non-first beat accepted in IDLE is dropped; there is no other state change.
  - A beat arriving at k == NIBBLES without in_last is dropped, and the state returns to IDLE with no result.
  - A beat with in_last at k == NIBBLES is likewise dropped with no result.
- out_valid clears on out_ready unless a new completion occurs in the same cycle; in that case it stays set with the new data.
- sum, cout and ovf are stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid = 0, sum = 0, cout = 0, ovf = 0, err = 0; state IDLE, k = 0, c = 0. in_ready = 1 in the cycle after reset.
- rst during ACCUM discards the partial operation. rst while out_valid drops the result.
- Latency: out_valid rises on the clock edge that accepts the last beat, so the result is visible the following cycle.
- Throughput: one nibble per cycle. Back-to-back operations run with no bubble when out_ready is held high.
- err is a single-cycle pulse registered on the accepting edge.
- All outputs are registered except in_ready, which is combinational from out_valid and out_ready.

## Test plan
- A=0x1234, B=0x0FFF, cin=0, four beats with out_ready=1 → sum=0x2233, cout=0, ovf=0; out_valid high for exactly one cycle.
- A=0xFFFF, B=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then A=0x7FFF, B=0x0001 → sum=0x8000, cout=0, ovf=1.
- A=0x0F, B=0x01, cin=1, two beats (first, then last) → sum=0x0011, cout=0, and upper nibbles are zero.
- Hold out_ready=0 after a completion → in_ready=0 and sum stays stable for 5 cycles. Then raise out_ready together with the first beat of A=0x0001, B=0x0001 → that beat is accepted in the same cycle; the final result is 0x0002.
- Non-first beat in IDLE → err pulses and there is no result. Five beats without in_last → err pulses on the fifth beat and there is no result. A first beat mid-operation restarts cleanly and yields the correct sum.
- Assert rst after two nibbles → out_valid=0. A fresh operation A=0x8000, B=0x8000 → sum=0x0000, cout=1, ovf=1.
